// File: rtl/dd_pkg.sv
// rtl/dd_pkg.sv - shared register map and field positions for the CPU-side 64DD responder
package dd_pkg;

    localparam logic [3:0] ADDR_SCR = 4'h0;
    localparam logic [3:0] ADDR_CMD = 4'h4;
    localparam logic [3:0] ADDR_RSP = 4'h8;
    localparam logic [3:0] ADDR_BM  = 4'hC;

    localparam int SCR_CMD_PEND = 0;
    localparam int SCR_BM_PEND  = 1;
    localparam int SCR_HR_PEND  = 2;
    localparam int SCR_HR_LEVEL = 3;
    localparam int SCR_CMD_IE   = 8;
    localparam int SCR_BM_IE    = 9;
    localparam int SCR_HR_IE    = 10;
    localparam int SCR_CMD_DONE = 16;
    localparam int SCR_BM_CLEAR = 17;
    localparam int SCR_HR_CLEAR = 18;

    typedef enum logic [1:0] {
        REG_SCR = ADDR_SCR[3:2],
        REG_CMD = ADDR_CMD[3:2],
        REG_RSP = ADDR_RSP[3:2],
        REG_BM  = ADDR_BM[3:2]
    } reg_sel_e;

    function automatic reg_sel_e addr_to_sel(input logic [3:0] addr);
        return reg_sel_e'(addr[3:2]);
    endfunction

endpackage

// File: rtl/cpu_dd.sv
// rtl/cpu_dd.sv - CPU register bank capturing 64DD commands and bus-master requests
module cpu_dd
    import dd_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        bus_request_i,
    input  logic [3:0]  bus_wmask_i,
    input  logic [3:0]  bus_address_i,
    input  logic [31:0] bus_wdata_i,
    output logic        bus_ack_o,
    output logic [31:0] bus_rdata_o,
    input  logic        dd_hard_reset_i,
    input  logic        dd_cmd_request_i,
    input  logic [7:0]  dd_command_i,
    input  logic [15:0] dd_data_input_i,
    input  logic        dd_bm_request_i,
    input  logic [15:0] dd_bm_control_i,
    output logic        dd_cmd_ack_o,
    output logic [15:0] dd_status_o,
    output logic [15:0] dd_data_output_o,
    output logic [15:0] dd_bm_status_o,
    output logic        irq_o
);

    logic        cmd_req_prev_q, bm_req_prev_q, hr_prev_q;
    logic        cmd_pend_q, cmd_pend_d;
    logic        bm_pend_q, bm_pend_d;
    logic        hr_pend_q, hr_pend_d;
    logic [2:0]  irq_en_q, irq_en_d;        // {hr, bm, cmd}
    logic [7:0]  cmd_q, cmd_d;
    logic [15:0] din_q, din_d;
    logic [31:0] rsp_q, rsp_d;
    logic [15:0] bmc_q, bmc_d;
    logic [15:0] bms_q, bms_d;
    logic        ack_q, ack_d;
    logic        ack_pend_q, ack_pend_d;    // cmd_done accepted, ack goes out next cycle
    logic        cmd_ack_q, cmd_ack_d;
    logic        irq_q, irq_d;
    logic [31:0] rdata_q, rdata_d;

    logic        cmd_edge, bm_edge, hr_edge;
    logic        wr, wr_scr, wr_rsp, wr_bm;
    logic        done_wr, bm_clr_wr, hr_clr_wr;
    logic [31:0] scr_rd;
    reg_sel_e    sel;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = &{1'b0, bus_address_i[1:0]};

    // Edge detection, register decode, flag/data next state and read mux
    always_comb begin
        // Requests from the N64 side are ignored while the drive is held in hard reset
        cmd_edge  = dd_cmd_request_i & ~cmd_req_prev_q & ~dd_hard_reset_i;
        bm_edge   = dd_bm_request_i & ~bm_req_prev_q & ~dd_hard_reset_i;
        hr_edge   = dd_hard_reset_i & ~hr_prev_q;

        sel       = addr_to_sel(bus_address_i);
        wr        = bus_request_i & (|bus_wmask_i);
        wr_scr    = wr & (sel == REG_SCR);
        wr_rsp    = wr & (sel == REG_RSP);
        wr_bm     = wr & (sel == REG_BM);
        done_wr   = wr_scr & bus_wmask_i[2] & bus_wdata_i[SCR_CMD_DONE];
        bm_clr_wr = wr_scr & bus_wmask_i[2] & bus_wdata_i[SCR_BM_CLEAR];
        hr_clr_wr = wr_scr & bus_wmask_i[2] & bus_wdata_i[SCR_HR_CLEAR];

        cmd_d      = cmd_q;
        din_d      = din_q;
        bmc_d      = bmc_q;
        irq_en_d   = irq_en_q;
        cmd_pend_d = cmd_pend_q;
        bm_pend_d  = bm_pend_q;
        hr_pend_d  = hr_pend_q;
        rsp_d      = rsp_q;
        bms_d      = bms_q;

        if (wr_scr && bus_wmask_i[1]) begin
            irq_en_d = {bus_wdata_i[SCR_HR_IE], bus_wdata_i[SCR_BM_IE], bus_wdata_i[SCR_CMD_IE]};
        end

        // A fresh request edge beats a clear in the same cycle
        if (done_wr)   cmd_pend_d = 1'b0;
        if (cmd_edge) begin
            cmd_pend_d = 1'b1;
            cmd_d      = dd_command_i;
            din_d      = dd_data_input_i;
        end
        if (bm_clr_wr) bm_pend_d = 1'b0;
        if (bm_edge) begin
            bm_pend_d = 1'b1;
            bmc_d     = dd_bm_control_i;
        end
        if (hr_clr_wr) hr_pend_d = 1'b0;

        for (int b = 0; b < 4; b++) begin
            if (wr_rsp && bus_wmask_i[b]) rsp_d[8*b +: 8] = bus_wdata_i[8*b +: 8];
        end
        for (int b = 2; b < 4; b++) begin
            if (wr_bm && bus_wmask_i[b]) bms_d[8*(b-2) +: 8] = bus_wdata_i[8*b +: 8];
        end

        // Hard reset wipes the handshake state but keeps the interrupt enables
        if (hr_edge) begin
            cmd_pend_d = 1'b0;
            bm_pend_d  = 1'b0;
            hr_pend_d  = 1'b1;
            rsp_d      = '0;
            bms_d      = '0;
        end

        ack_pend_d = done_wr & cmd_pend_q & ~hr_edge;
        cmd_ack_d  = ack_pend_q & ~hr_edge;
        ack_d      = bus_request_i;
        irq_d      = |({hr_pend_q, bm_pend_q, cmd_pend_q} & irq_en_q);

        scr_rd               = '0;
        scr_rd[SCR_CMD_PEND] = cmd_pend_q;
        scr_rd[SCR_BM_PEND]  = bm_pend_q;
        scr_rd[SCR_HR_PEND]  = hr_pend_q;
        scr_rd[SCR_HR_LEVEL] = dd_hard_reset_i;
        scr_rd[SCR_CMD_IE]   = irq_en_q[0];
        scr_rd[SCR_BM_IE]    = irq_en_q[1];
        scr_rd[SCR_HR_IE]    = irq_en_q[2];

        rdata_d = '0;
        if (bus_request_i) begin
            case (sel)
                REG_SCR: rdata_d = scr_rd;
                REG_CMD: rdata_d = {din_q, 8'h00, cmd_q};
                REG_RSP: rdata_d = rsp_q;
                REG_BM:  rdata_d = {bms_q, bmc_q};
                default: rdata_d = '0;
            endcase
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cmd_req_prev_q <= 1'b0;
            bm_req_prev_q  <= 1'b0;
            hr_prev_q      <= 1'b0;
            cmd_pend_q     <= 1'b0;
            bm_pend_q      <= 1'b0;
            hr_pend_q      <= 1'b0;
            irq_en_q       <= '0;
            cmd_q          <= '0;
            din_q          <= '0;
            rsp_q          <= '0;
            bmc_q          <= '0;
            bms_q          <= '0;
            ack_q          <= 1'b0;
            ack_pend_q     <= 1'b0;
            cmd_ack_q      <= 1'b0;
            irq_q          <= 1'b0;
            rdata_q        <= '0;
        end else begin
            cmd_req_prev_q <= dd_cmd_request_i;
            bm_req_prev_q  <= dd_bm_request_i;
            hr_prev_q      <= dd_hard_reset_i;
            cmd_pend_q     <= cmd_pend_d;
            bm_pend_q      <= bm_pend_d;
            hr_pend_q      <= hr_pend_d;
            irq_en_q       <= irq_en_d;
            cmd_q          <= cmd_d;
            din_q          <= din_d;
            rsp_q          <= rsp_d;
            bmc_q          <= bmc_d;
            bms_q          <= bms_d;
            ack_q          <= ack_d;
            ack_pend_q     <= ack_pend_d;
            cmd_ack_q      <= cmd_ack_d;
            irq_q          <= irq_d;
            rdata_q        <= rdata_d;
        end
    end

    assign bus_ack_o        = ack_q;
    assign bus_rdata_o      = rdata_q;
    assign dd_cmd_ack_o     = cmd_ack_q;
    assign dd_status_o      = rsp_q[15:0];
    assign dd_data_output_o = rsp_q[31:16];
    assign dd_bm_status_o   = bms_q;
    assign irq_o            = irq_q;

endmodule

// File: tb/tb_cpu_dd.sv
// tb/tb_cpu_dd.sv - scoreboard bench for cpu_dd with a register-level reference model
module tb_cpu_dd;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        bus_request_i = 1'b0;
    logic [3:0]  bus_wmask_i = '0;
    logic [3:0]  bus_address_i = '0;
    logic [31:0] bus_wdata_i = '0;
    logic        bus_ack_o;
    logic [31:0] bus_rdata_o;
    logic        dd_hard_reset_i = 1'b0;
    logic        dd_cmd_request_i = 1'b0;
    logic [7:0]  dd_command_i = '0;
    logic [15:0] dd_data_input_i = '0;
    logic        dd_bm_request_i = 1'b0;
    logic [15:0] dd_bm_control_i = '0;
    logic        dd_cmd_ack_o;
    logic [15:0] dd_status_o;
    logic [15:0] dd_data_output_o;
    logic [15:0] dd_bm_status_o;
    logic        irq_o;

    cpu_dd dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .bus_request_i    (bus_request_i),
        .bus_wmask_i      (bus_wmask_i),
        .bus_address_i    (bus_address_i),
        .bus_wdata_i      (bus_wdata_i),
        .bus_ack_o        (bus_ack_o),
        .bus_rdata_o      (bus_rdata_o),
        .dd_hard_reset_i  (dd_hard_reset_i),
        .dd_cmd_request_i (dd_cmd_request_i),
        .dd_command_i     (dd_command_i),
        .dd_data_input_i  (dd_data_input_i),
        .dd_bm_request_i  (dd_bm_request_i),
        .dd_bm_control_i  (dd_bm_control_i),
        .dd_cmd_ack_o     (dd_cmd_ack_o),
        .dd_status_o      (dd_status_o),
        .dd_data_output_o (dd_data_output_o),
        .dd_bm_status_o   (dd_bm_status_o),
        .irq_o            (irq_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int failed = 0;

    // Scoreboard queues: bus responses and cmd_ack pulses, keyed by expected cycle
    int          q_cyc[$];
    bit          q_chk[$];
    logic [31:0] q_val[$];
    int          q_ack[$];

    // Reference model of the visible register state
    bit          m_cmd_pend, m_bm_pend, m_hr_pend, m_hr_lvl;
    bit [2:0]    m_en;   // {hr, bm, cmd}
    logic [7:0]  m_cmd;
    logic [15:0] m_din, m_bmc, m_bms;
    logic [31:0] m_rsp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        failed++;
        $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] m_read(input int r);
        case (r)
            0: return {21'b0, m_en, 4'b0, m_hr_lvl, m_hr_pend, m_bm_pend, m_cmd_pend};
            1: return {m_din, 8'h00, m_cmd};
            2: return m_rsp;
            default: return {m_bms, m_bmc};
        endcase
    endfunction

    task automatic model_clear();
        m_cmd_pend = 0; m_bm_pend = 0; m_hr_pend = 0; m_hr_lvl = 0;
        m_en = '0; m_cmd = '0; m_din = '0; m_rsp = '0; m_bmc = '0; m_bms = '0;
    endtask

    task automatic model_write(input int r, input logic [3:0] mask, input logic [31:0] data);
        if (r == 0) begin
            if (mask[1]) m_en = data[10:8];
            if (mask[2]) begin
                if (data[16] && m_cmd_pend) begin
                    q_ack.push_back(cyc + 2);
                    m_cmd_pend = 0;
                end
                if (data[17]) m_bm_pend = 0;
                if (data[18]) m_hr_pend = 0;
            end
        end else if (r == 2) begin
            for (int b = 0; b < 4; b++) if (mask[b]) m_rsp[8*b +: 8] = data[8*b +: 8];
        end else if (r == 3) begin
            for (int b = 2; b < 4; b++) if (mask[b]) m_bms[8*(b-2) +: 8] = data[8*b +: 8];
        end
    endtask

    task automatic drive_bus(input int r, input logic [3:0] mask, input logic [31:0] data);
        logic [1:0] lo;
        lo = 2'($urandom);
        bus_request_i = 1'b1;
        bus_address_i = {r[1:0], lo};
        bus_wmask_i   = mask;
        bus_wdata_i   = data;
    endtask

    task automatic release_bus();
        bus_request_i = 1'b0;
        bus_wmask_i   = '0;
        bus_wdata_i   = $urandom;
    endtask

    task automatic bus_write(input int r, input logic [3:0] mask, input logic [31:0] data);
        drive_bus(r, mask, data);
        q_cyc.push_back(cyc + 1); q_chk.push_back(1'b0); q_val.push_back('0);
        model_write(r, mask, data);
        @(negedge clk);
        release_bus();
        @(negedge clk);
    endtask

    task automatic bus_read(input int r);
        drive_bus(r, 4'h0, $urandom);
        q_cyc.push_back(cyc + 1); q_chk.push_back(1'b1); q_val.push_back(m_read(r));
        @(negedge clk);
        release_bus();
        @(negedge clk);
    endtask

    task automatic cmd_pulse(input logic [7:0] c, input logic [15:0] d);
        dd_command_i = c; dd_data_input_i = d; dd_cmd_request_i = 1'b1;
        if (!m_hr_lvl) begin m_cmd_pend = 1; m_cmd = c; m_din = d; end
        @(negedge clk);
        dd_cmd_request_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic bm_pulse(input logic [15:0] c);
        dd_bm_control_i = c; dd_bm_request_i = 1'b1;
        if (!m_hr_lvl) begin m_bm_pend = 1; m_bmc = c; end
        @(negedge clk);
        dd_bm_request_i = 1'b0;
        @(negedge clk);
    endtask

    // cmd_done write and a new command edge land on the same clock edge
    task automatic collide(input logic [7:0] c, input logic [15:0] d);
        drive_bus(0, 4'h4, 32'h0001_0000);
        dd_command_i = c; dd_data_input_i = d; dd_cmd_request_i = 1'b1;
        q_cyc.push_back(cyc + 1); q_chk.push_back(1'b0); q_val.push_back('0);
        model_write(0, 4'h4, 32'h0001_0000);
        if (!m_hr_lvl) begin m_cmd_pend = 1; m_cmd = c; m_din = d; end
        @(negedge clk);
        release_bus();
        dd_cmd_request_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic hr_set(input bit lvl);
        dd_hard_reset_i = lvl;
        if (lvl && !m_hr_lvl) begin
            m_cmd_pend = 0; m_bm_pend = 0; m_hr_pend = 1; m_rsp = '0; m_bms = '0;
        end
        m_hr_lvl = lvl;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_outs();
        check("irq", irq_o, (m_cmd_pend & m_en[0]) | (m_bm_pend & m_en[1]) | (m_hr_pend & m_en[2]));
        check("dd_status", dd_status_o, m_rsp[15:0]);
        check("dd_data_output", dd_data_output_o, m_rsp[31:16]);
        check("dd_bm_status", dd_bm_status_o, m_bms);
    endtask

    // System reset with a coincident bus write that must be neither acked nor applied
    task automatic sys_reset(input bit hold_bm, input logic [15:0] bmc);
        reset_i = 1'b1;
        drive_bus(2, 4'hF, 32'hDEAD_BEEF);
        dd_bm_control_i = bmc;
        dd_bm_request_i = hold_bm;
        @(negedge clk);
        release_bus();
        @(negedge clk);
        reset_i = 1'b0;
        model_clear();
        if (hold_bm) begin m_bm_pend = 1; m_bmc = bmc; end
        @(negedge clk);
        dd_bm_request_i = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: pops scoreboard entries whenever the DUT responds
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus_ack_o) begin
                if (q_cyc.size() == 0) begin
                    fail_now("unexpected_bus_ack", 32'd1, 32'd0);
                end else begin
                    check("bus_ack_cycle", cyc, q_cyc[0]);
                    if (q_chk[0]) check("bus_rdata", bus_rdata_o, q_val[0]);
                    void'(q_cyc.pop_front()); void'(q_chk.pop_front()); void'(q_val.pop_front());
                end
            end else begin
                check("rdata_idle", bus_rdata_o, 32'd0);
                if (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
                    fail_now("missing_bus_ack", 32'd0, 32'd1);
                    void'(q_cyc.pop_front()); void'(q_chk.pop_front()); void'(q_val.pop_front());
                end
            end
            if (dd_cmd_ack_o) begin
                if (q_ack.size() == 0) fail_now("unexpected_cmd_ack", 32'd1, 32'd0);
                else begin
                    check("cmd_ack_cycle", cyc, q_ack[0]);
                    void'(q_ack.pop_front());
                end
            end else if (q_ack.size() > 0 && q_ack[0] <= cyc) begin
                fail_now("missing_cmd_ack", 32'd0, 32'd1);
                void'(q_ack.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        model_clear();
        @(negedge clk);
        sys_reset(1'b0, 16'h0);
        check_outs();
        for (int r = 0; r < 4; r++) bus_read(r);

        // Command capture and interrupt
        bus_write(0, 4'h2, 32'h0000_0700);
        cmd_pulse(8'h08, 16'h1234);
        bus_read(1);
        bus_read(0);
        check_outs();

        // Respond and acknowledge
        bus_write(2, 4'hF, 32'hBEEF_0040);
        check_outs();
        bus_write(0, 4'h4, 32'h0001_0000);
        check_outs();
        bus_read(0);
        bus_write(0, 4'h4, 32'h0001_0000);   // no command pending: no ack

        // Byte masking
        bus_write(2, 4'hF, 32'h0);
        bus_write(2, 4'h2, 32'hAABB_CCDD);
        bus_read(2);
        check_outs();

        // Collision of cmd_done with a new command edge
        cmd_pulse(8'h01, 16'h1111);
        collide(8'h0A, 16'h2222);
        bus_read(0);
        bus_read(1);
        check_outs();

        // Bus master
        bm_pulse(16'h0003);
        bus_read(3);
        bus_read(0);
        bus_write(3, 4'hC, 32'h0001_0000);
        check_outs();
        bus_write(0, 4'h4, 32'h0002_0000);
        bus_read(0);
        check_outs();

        // Hard reset
        cmd_pulse(8'h05, 16'h5555);
        bus_write(2, 4'hF, 32'hFFFF_FFFF);
        hr_set(1'b1);
        bus_read(0);
        bus_read(2);
        check_outs();
        cmd_pulse(8'h77, 16'h7777);
        bm_pulse(16'h0F0F);
        bus_read(0);
        bus_read(1);
        bus_write(2, 4'h3, 32'h0000_1234);
        check_outs();
        bus_write(0, 4'h4, 32'h0004_0000);
        hr_set(1'b0);
        bus_read(0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1: cmd_pulse(8'($urandom), 16'($urandom));
                2:    bm_pulse(16'($urandom));
                3, 4: bus_write($urandom_range(0, 3), 4'($urandom_range(1, 15)), $urandom);
                5, 6, 7: bus_read($urandom_range(0, 3));
                8:    collide(8'($urandom), 16'($urandom));
                default: begin
                    if ($urandom_range(0, 2) == 0) hr_set(!m_hr_lvl);
                    else bus_read(0);
                end
            endcase
            check_outs();
        end
        if (m_hr_lvl) hr_set(1'b0);

        // Reset mid-run with bm_request already high at reset release
        bus_write(0, 4'h2, 32'h0000_0700);
        sys_reset(1'b1, 16'hBEEF);
        check_outs();
        bus_read(0);
        bus_read(3);
        bus_read(2);

        repeat (4) @(negedge clk);
        check("bus_queue_drained", q_cyc.size(), 32'd0);
        check("ack_queue_drained", q_ack.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
